// File: rtl/i2c_target_rx_if.sv
// Pin-side and fabric-side signals of the write-only I2C target receiver.
// Received bytes use a push-only handshake. RX_VALID is high for exactly one
// CLK cycle whenever RX_DATA holds a new byte. There is no ready or backpressure:
// the consumer must take the byte in that cycle. RX_DATA holds its value until
// the next RX_VALID.
interface i2c_target_rx_if;
   logic       SCL_IN;
   logic       SDA_IN;
   logic       SDA_OE;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RX_START;
   logic       RX_STOP;
   logic       BUSY;
   logic [2:0] fsm_state;

   modport slave (
      input  SCL_IN, SDA_IN,
      output SDA_OE, RX_DATA, RX_VALID, RX_START, RX_STOP, BUSY, fsm_state
   );

   modport master (
      output SCL_IN, SDA_IN,
      input  SDA_OE, RX_DATA, RX_VALID, RX_START, RX_STOP, BUSY, fsm_state
   );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target. Synchronizes and deglitches SCL/SDA, detects
// START/STOP, matches a 7-bit write address, shifts in bytes and ACKs them.
module i2c_target_rx #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter logic [3:0] FILTER_LEN = 4'd3
) (
   input  logic            CLK,
   input  logic            RST_N,
   i2c_target_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_DATA     = 3'd3,
      S_DATA_ACK = 3'd4,
      S_IGNORE   = 3'd5
   } state_t;

   // Bit 0 carries SCL and bit 1 carries SDA throughout the input path.
   logic [1:0]      sync_a, sync_b;
   logic [1:0]      filt, prev;
   logic [1:0][3:0] cnt;

   logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] shifted;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_start_q, rx_start_d;
   logic       rx_stop_q, rx_stop_d;
   logic       busy_q, busy_d;

   // Two-flop synchronizer for both pins; idle bus level is high.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_a <= 2'b11;
         sync_b <= 2'b11;
      end else begin
         sync_a <= {bus.SDA_IN, bus.SCL_IN};
         sync_b <= sync_a;
      end
   end

   // Glitch filter: a new level must persist FILTER_LEN cycles before it is accepted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         filt <= 2'b11;
         cnt  <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == filt[i]) begin
               cnt[i] <= 4'd0;
            end else if (cnt[i] == FILTER_LEN - 4'd1) begin
               filt[i] <= sync_b[i];
               cnt[i]  <= 4'd0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   // Registered edge and bus-condition pulses from the filtered lines.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prev      <= 2'b11;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_bit   <= 1'b1;
      end else begin
         prev      <= filt;
         scl_rise  <= filt[0] & ~prev[0];
         scl_fall  <= ~filt[0] & prev[0];
         start_det <= ~filt[1] & prev[1] & filt[0];
         stop_det  <= filt[1] & ~prev[1] & filt[0];
         sda_bit   <= filt[1];
      end
   end

   assign shifted = {shift_q[6:0], sda_bit};

   // Protocol state and all fabric/pin outputs are registered here.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         rx_start_q <= 1'b0;
         rx_stop_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_start_q <= rx_start_d;
         rx_stop_q  <= rx_stop_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic: START/STOP override everything, then per-state bit handling.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_start_d = 1'b0;
      rx_stop_d  = 1'b0;
      busy_d     = busy_q;

      if (start_det) begin
         state_d    = S_ADDR;
         bit_cnt_d  = 4'd0;
         sda_oe_d   = 1'b0;
         rx_start_d = 1'b1;
         busy_d     = 1'b1;
      end else if (stop_det) begin
         state_d   = S_IDLE;
         sda_oe_d  = 1'b0;
         rx_stop_d = 1'b1;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               sda_oe_d = 1'b0;
            end
            S_ADDR: begin
               if (scl_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (shifted[7:1] == DEV_ADDR && !shifted[0]) begin
                        state_d = S_ADDR_ACK;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end
            // First SCL fall after the 8th bit drives ACK, the next one releases it.
            S_ADDR_ACK, S_DATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     state_d   = S_DATA;
                     bit_cnt_d = 4'd0;
                  end
               end
            end
            S_DATA: begin
               if (scl_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     rx_data_d  = shifted;
                     rx_valid_d = 1'b1;
                     state_d    = S_DATA_ACK;
                  end
               end
            end
            S_IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = S_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.SDA_OE    = sda_oe_q;
   assign bus.RX_DATA   = rx_data_q;
   assign bus.RX_VALID  = rx_valid_q;
   assign bus.RX_START  = rx_start_q;
   assign bus.RX_STOP   = rx_stop_q;
   assign bus.BUSY      = busy_q;
   assign bus.fsm_state = state_q;

endmodule
